// File: rtl/i_scan_pkg.sv
// rtl/i_scan_pkg.sv - shared state type and default widths for the raster-scan sequencer
package i_scan_pkg;

    localparam int SCAN_CNT_BITS  = 13;
    localparam int SCAN_ADDR_BITS = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - zero-based index counter that wraps to 0 after reaching its limit
module scan_axis_counter
    import i_scan_pkg::*;
#(
    parameter int W = SCAN_CNT_BITS
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         at_limit
);

    assign at_limit = (value == limit);

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= '0;
        end else if (inc) begin
            value <= at_limit ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/i_scan_ctrl.sv
// rtl/i_scan_ctrl.sv - raster-scan sequencer emitting row/col/address beats over a valid/ready handshake
module i_scan_ctrl
    import i_scan_pkg::*;
#(
    parameter int CNT_BITS  = SCAN_CNT_BITS,
    parameter int ADDR_BITS = SCAN_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_BITS-1:0]  img_width,
    input  logic [CNT_BITS-1:0]  img_height,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] line_stride,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [CNT_BITS-1:0]  row,
    output logic [CNT_BITS-1:0]  col,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last_col,
    output logic                 last_pixel,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    scan_state_t state, state_next;

    logic [CNT_BITS-1:0]  width_m1_q, height_m1_q;
    logic [ADDR_BITS-1:0] stride_q, row_base_q, addr_q;
    logic                 cfg_err_q;
    logic                 col_at_limit, row_at_limit;

    logic cfg_bad, start_accept, scanning, abort_now, handshake;

    assign cfg_bad      = (img_width == '0) || (img_height == '0);
    assign start_accept = (state == IDLE) && start && !cfg_bad;
    assign scanning     = (state == SCAN);
    assign abort_now    = scanning && abort;
    // abort wins over a handshake in the same cycle, including the final beat
    assign handshake    = scanning && out_ready && !abort;

    scan_axis_counter #(.W(CNT_BITS)) u_col_cnt (
        .clk      (clk),
        .clear    (clear),
        .load     (start_accept || abort_now),
        .inc      (handshake),
        .limit    (width_m1_q),
        .value    (col),
        .at_limit (col_at_limit)
    );

    scan_axis_counter #(.W(CNT_BITS)) u_row_cnt (
        .clk      (clk),
        .clear    (clear),
        .load     (start_accept || abort_now),
        .inc      (handshake && col_at_limit),
        .limit    (height_m1_q),
        .value    (row),
        .at_limit (row_at_limit)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_accept) state_next = SCAN;
            SCAN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready && col_at_limit && row_at_limit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            width_m1_q  <= '0;
            height_m1_q <= '0;
            stride_q    <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= (state == IDLE) && start && cfg_bad;
            if (start_accept) begin
                width_m1_q  <= img_width - CNT_BITS'(1);
                height_m1_q <= img_height - CNT_BITS'(1);
                stride_q    <= line_stride;
                row_base_q  <= base_addr;
                addr_q      <= base_addr;
            end else if (abort_now) begin
                row_base_q <= '0;
                addr_q     <= '0;
            end else if (handshake) begin
                if (!col_at_limit) begin
                    addr_q <= addr_q + ADDR_BITS'(1);
                end else if (!row_at_limit) begin
                    row_base_q <= row_base_q + stride_q;
                    addr_q     <= row_base_q + stride_q;
                end else begin
                    row_base_q <= '0;
                    addr_q     <= '0;
                end
            end
        end
    end

    assign out_valid  = scanning;
    assign addr       = addr_q;
    assign last_col   = scanning && col_at_limit;
    assign last_pixel = last_col && row_at_limit;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_i_scan_ctrl.sv
// tb/tb_i_scan_ctrl.sv - directed and randomized checks of i_scan_ctrl against a raster-order model
module tb_i_scan_ctrl;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] img_width = '0;
    logic [12:0] img_height = '0;
    logic [25:0] base_addr = '0;
    logic [25:0] line_stride = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [12:0] row;
    logic [12:0] col;
    logic [25:0] addr;
    logic        last_col;
    logic        last_pixel;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    i_scan_ctrl dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .abort       (abort),
        .img_width   (img_width),
        .img_height  (img_height),
        .base_addr   (base_addr),
        .line_stride (line_stride),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .row         (row),
        .col         (col),
        .addr        (addr),
        .last_col    (last_col),
        .last_pixel  (last_pixel),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"},  32'(busy),      32'd0);
        check({tag, ".done"},  32'(done),      32'd0);
        check({tag, ".row"},   32'(row),       32'd0);
        check({tag, ".col"},   32'(col),       32'd0);
        check({tag, ".addr"},  32'(addr),      32'd0);
        check({tag, ".lastp"}, 32'(last_pixel), 32'd0);
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready
    task automatic run_scan(input int w, input int h, input logic [25:0] base, input logic [25:0] stride,
                            input int mode, input int abort_at, input int restart_at);
        int        k = 0;
        int        cyc = 0;
        int        total = w * h;
        int        r, c;
        logic      rdy;
        bit        aborted = 0;
        logic [25:0] ea;
        @(negedge clk);
        img_width = 13'(w); img_height = 13'(h);
        base_addr = base;   line_stride = stride;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        img_width   = 13'($urandom_range(0, 8));
        img_height  = 13'($urandom_range(0, 8));
        base_addr   = 26'($urandom);
        line_stride = 26'($urandom);
        while (k < total && cyc < 300 && !aborted) begin
            r  = k / w;
            c  = k % w;
            ea = base + 26'(r) * stride + 26'(c);
            check("beat.valid", 32'(out_valid), 32'd1);
            check("beat.row",   32'(row),       32'(r));
            check("beat.col",   32'(col),       32'(c));
            check("beat.addr",  32'(addr),      32'(ea));
            check("beat.lastc", 32'(last_col),  32'(c == w - 1));
            check("beat.lastp", 32'(last_pixel), 32'(k == total - 1));
            check("beat.busy",  32'(busy),      32'd1);
            check("beat.done",  32'(done),      32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = (cyc == restart_at);
            if (k == abort_at && rdy) begin
                abort   = 1'b1;
                aborted = 1;
            end
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (rdy && !aborted) k++;
            cyc++;
        end
        out_ready = 1'b0;
        check("scan.timeout", 32'(cyc < 300), 32'd1);
        if (aborted) begin
            check_idle("abort");
        end else begin
            check("end.done",  32'(done),      32'd1);
            check("end.busy",  32'(busy),      32'd1);
            check("end.valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            check_idle("post_done");
        end
    endtask

    initial begin
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check_idle("reset");
        check("reset.cfg_err", 32'(cfg_err), 32'd0);

        run_scan(3, 2, 26'd100, 26'd4, 0, -1, -1);
        run_scan(3, 2, 26'd100, 26'd4, 1, -1, -1);

        @(negedge clk);
        img_width = 13'd0; img_height = 13'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err.pulse", 32'(cfg_err),   32'd1);
        check("cfg_err.busy",  32'(busy),      32'd0);
        check("cfg_err.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("cfg_err.clear", 32'(cfg_err),   32'd0);
        check("cfg_err.busy2", 32'(busy),      32'd0);
        run_scan(2, 2, 26'd40, 26'd8, 0, -1, -1);

        run_scan(4, 4, 26'd1000, 26'd16, 0, 4, 2);
        run_scan(4, 4, 26'd2000, 26'd16, 1, -1, 3);

        @(negedge clk);
        img_width = 13'd3; img_height = 13'd3;
        base_addr = 26'd500; line_stride = 26'd10;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("clear.pre_row",  32'(row),  32'd1);
        check("clear.pre_col",  32'(col),  32'd2);
        check("clear.pre_addr", 32'(addr), 32'd512);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        check_idle("clear");
        run_scan(3, 3, 26'd7000, 26'd10, 0, -1, -1);

        run_scan(1, 1, 26'h3FF_FFFF, 26'd5, 0, -1, -1);
        run_scan(1, 2, 26'h3FF_FFFF, 26'd2, 0, -1, -1);
        run_scan(5, 3, 26'h3FF_FFFD, 26'h3FF_FFF0, 2, -1, -1);

        for (int i = 0; i < 6; i++) begin
            run_scan(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                     26'($urandom), 26'($urandom), 2, -1, -1);
        end

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("idle_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
